// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Request bundle, source encoding and the x0-masked one-hot helper.
package wb_arb_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_PIPE,
    SRC_MDU,
    SRC_FPU
  } wb_src_e;

  function automatic logic [31:0] onehot32(input logic [4:0] rd);
    logic [31:0] m;
    m = '0;
    if (rd != 5'd0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-port arbiter bus: pipeline, MUL/DIV and FPU requesters,
// register-file write port and hazard-side outputs.
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            fpu_valid;
  logic            fpu_ready;
  logic [4:0]      fpu_rd;
  logic [XLEN-1:0] fpu_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pend_mask;
  logic            stall_req;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output mdu_valid, mdu_rd, mdu_data,
    output fpu_valid, fpu_rd, fpu_data,
    input  mdu_ready, fpu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  pend_mask, stall_req
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  fpu_valid, fpu_rd, fpu_data,
    output mdu_ready, fpu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output pend_mask, stall_req
  );

endinterface

// File: rtl/wb_fifo.sv
// Small side-result FIFO with wrap-bit pointers.
// Also reports the destinations of all live entries.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  wb_req_t     din,
  input  logic        pop,
  output wb_req_t     head,
  output logic        full,
  output logic        empty,
  output logic [31:0] pend
);

  localparam int AW = $clog2(QDEPTH);

  wb_req_t     mem [QDEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] cnt;

  assign cnt   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // slot i is live when its distance from the head is below the fill level
  always_comb begin
    pend = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      logic [AW-1:0] off;
      off = AW'(i) - rd_ptr[AW-1:0];
      if ({1'b0, off} < cnt) pend = pend | onehot32(mem[i].rd);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Integer RF write-port arbiter: pipeline WB first, buffered
// MUL/DIV and FPU results round-robin in idle slots.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_LIM = 8
) (
  input logic               clk,
  input logic               Rst_n,
  wb_port_arbiter_if.slave  bus
);

  localparam int            CW  = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  wb_req_t       m_din, f_din;
  wb_req_t       m_head, f_head, gnt;
  logic          m_full, m_empty, f_full, f_empty;
  logic          m_push, f_push, m_pop, f_pop;
  logic [31:0]   m_pend, f_pend;
  logic [CW-1:0] m_cnt, f_cnt, m_cnt_nxt, f_cnt_nxt;
  logic          rr_fpu, gnt_v, rf_side;
  wb_src_e       src;

  assign bus.mdu_ready = Rst_n && !m_full;
  assign bus.fpu_ready = Rst_n && !f_full;
  assign m_push = bus.mdu_valid && bus.mdu_ready;
  assign f_push = bus.fpu_valid && bus.fpu_ready;
  assign m_din  = '{rd: bus.mdu_rd, data: bus.mdu_data};
  assign f_din  = '{rd: bus.fpu_rd, data: bus.fpu_data};

  wb_fifo #(.QDEPTH(QDEPTH)) u_mdu_q (
    .clk(clk), .rst_n(Rst_n),
    .push(m_push), .din(m_din), .pop(m_pop),
    .head(m_head), .full(m_full), .empty(m_empty),
    .pend(m_pend)
  );

  wb_fifo #(.QDEPTH(QDEPTH)) u_fpu_q (
    .clk(clk), .rst_n(Rst_n),
    .push(f_push), .din(f_din), .pop(f_pop),
    .head(f_head), .full(f_full), .empty(f_empty),
    .pend(f_pend)
  );

  // a starving head takes the free slot ahead of round-robin
  always_comb begin
    src   = SRC_PIPE;
    gnt_v = 1'b1;
    if (bus.pipe_valid)                src = SRC_PIPE;
    else if (!m_empty && m_cnt >= LIM) src = SRC_MDU;
    else if (!f_empty && f_cnt >= LIM) src = SRC_FPU;
    else if (!m_empty && !f_empty)     src = rr_fpu ? SRC_FPU : SRC_MDU;
    else if (!m_empty)                 src = SRC_MDU;
    else if (!f_empty)                 src = SRC_FPU;
    else                               gnt_v = 1'b0;
  end

  assign m_pop = gnt_v && (src == SRC_MDU);
  assign f_pop = gnt_v && (src == SRC_FPU);

  always_comb begin
    case (src)
      SRC_MDU: gnt = m_head;
      SRC_FPU: gnt = f_head;
      default: gnt = '{rd: bus.pipe_rd, data: bus.pipe_data};
    endcase
  end

  always_comb begin
    m_cnt_nxt = m_cnt;
    f_cnt_nxt = f_cnt;
    if (m_pop)                      m_cnt_nxt = '0;
    else if (!m_empty && m_cnt < LIM) m_cnt_nxt = m_cnt + CW'(1);
    if (f_pop)                      f_cnt_nxt = '0;
    else if (!f_empty && f_cnt < LIM) f_cnt_nxt = f_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_cnt        <= '0;
      f_cnt        <= '0;
      rr_fpu       <= 1'b0;
      bus.stall_req <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      rf_side      <= 1'b0;
    end else begin
      m_cnt         <= m_cnt_nxt;
      f_cnt         <= f_cnt_nxt;
      bus.stall_req <= (m_cnt_nxt >= LIM) || (f_cnt_nxt >= LIM);
      if (!bus.pipe_valid && !m_empty && !f_empty)
        rr_fpu <= (src == SRC_MDU);
      bus.rf_we <= gnt_v && (gnt.rd != 5'd0);
      rf_side   <= gnt_v && (src != SRC_PIPE) && (gnt.rd != 5'd0);
      if (gnt_v) begin
        bus.rf_waddr <= gnt.rd;
        bus.rf_wdata <= gnt.data;
      end
    end
  end

  assign bus.pend_mask = m_pend | f_pend |
                         (rf_side ? onehot32(bus.rf_waddr) : 32'd0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int QD  = 2;
  localparam int LIM = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nmis  = 0;
  int   nexp  = 0;
  int   ndut  = 0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.QDEPTH(QD), .STARVE_LIM(LIM)) dut (
    .clk(clk),
    .Rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  ent_t        fq[$];
  int          mw      = 0;
  int          fw      = 0;
  bit          rr      = 1'b0;
  logic        e_we    = 1'b0;
  logic        e_side  = 1'b0;
  logic        e_stall = 1'b0;
  logic [4:0]  e_addr  = '0;
  logic [31:0] e_data  = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: each free slot goes to pipe, else a starving queue,
  // else alternate between queues; pushes only while below depth
  always @(posedge clk or negedge rst_n) begin : model
    int   src;
    bit   m_ne, f_ne, mpush, fpush;
    ent_t g;
    if (!rst_n) begin
      mq.delete();
      fq.delete();
      mw = 0; fw = 0; rr = 1'b0;
      e_we = 1'b0; e_side = 1'b0; e_stall = 1'b0;
      e_addr = '0; e_data = '0;
    end else begin
      m_ne  = mq.size() > 0;
      f_ne  = fq.size() > 0;
      mpush = bus.mdu_valid && (mq.size() < QD);
      fpush = bus.fpu_valid && (fq.size() < QD);
      src = 0;
      if (bus.pipe_valid)         src = 1;
      else if (m_ne && mw >= LIM) src = 2;
      else if (f_ne && fw >= LIM) src = 3;
      else if (m_ne && f_ne)      src = rr ? 3 : 2;
      else if (m_ne)              src = 2;
      else if (f_ne)              src = 3;
      if (!bus.pipe_valid && m_ne && f_ne) rr = (src == 2);
      g = '{rd: bus.pipe_rd, data: bus.pipe_data};
      if (src == 2) g = mq.pop_front();
      if (src == 3) g = fq.pop_front();
      if (src == 2) mw = 0;
      else if (m_ne && mw < LIM) mw++;
      if (src == 3) fw = 0;
      else if (f_ne && fw < LIM) fw++;
      if (src != 0) begin
        e_addr = g.rd;
        e_data = g.data;
      end
      e_we   = (src != 0) && (g.rd != 0);
      e_side = (src >= 2) && (g.rd != 0);
      if (e_we) nexp++;
      if (mpush) mq.push_back('{rd: bus.mdu_rd, data: bus.mdu_data});
      if (fpush) fq.push_back('{rd: bus.fpu_rd, data: bus.fpu_data});
      e_stall = (mw >= LIM) || (fw >= LIM);
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] pm;
    if (rst_n) begin
      pm = '0;
      foreach (mq[i]) if (mq[i].rd != 0) pm[mq[i].rd] = 1'b1;
      foreach (fq[i]) if (fq[i].rd != 0) pm[fq[i].rd] = 1'b1;
      if (e_side) pm[e_addr] = 1'b1;
      chk("m_rf_we", 32'(bus.rf_we), 32'(e_we));
      if (e_we) begin
        chk("m_waddr", 32'(bus.rf_waddr), 32'(e_addr));
        chk("m_wdata", bus.rf_wdata, e_data);
      end
      chk("m_stall", 32'(bus.stall_req), 32'(e_stall));
      chk("m_pend", bus.pend_mask, pm);
      chk("m_mrdy", 32'(bus.mdu_ready), 32'(mq.size() < QD));
      chk("m_frdy", 32'(bus.fpu_ready), 32'(fq.size() < QD));
      if (bus.rf_we) ndut++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.mdu_valid  = 1'b0; bus.mdu_rd  = '0; bus.mdu_data  = '0;
    bus.fpu_valid  = 1'b0; bus.fpu_rd  = '0; bus.fpu_data  = '0;
  endtask

  initial begin
    idle_in();
    repeat (3) tick();
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_pend", bus.pend_mask, 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_mrdy", 32'(bus.mdu_ready), 32'd1);
    chk("rst_frdy", 32'(bus.fpu_ready), 32'd1);

    // pipeline write, one cycle latency
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 32'hA5A5A5A5;
    tick();
    idle_in();
    chk("t1_we", 32'(bus.rf_we), 32'd1);
    chk("t1_addr", 32'(bus.rf_waddr), 32'd5);
    chk("t1_data", bus.rf_wdata, 32'hA5A5A5A5);
    tick();
    chk("t1_idle", 32'(bus.rf_we), 32'd0);

    // simultaneous side pushes drain MDU first
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h11;
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd9; bus.fpu_data = 32'h22;
    tick();
    idle_in();
    chk("t2_pend0", bus.pend_mask, 32'h280);
    tick();
    chk("t2_addr7", 32'(bus.rf_waddr), 32'd7);
    chk("t2_data7", bus.rf_wdata, 32'h11);
    chk("t2_pend1", bus.pend_mask, 32'h280);
    tick();
    chk("t2_addr9", 32'(bus.rf_waddr), 32'd9);
    chk("t2_data9", bus.rf_wdata, 32'h22);
    chk("t2_pend2", bus.pend_mask, 32'h200);
    tick();
    chk("t2_we", 32'(bus.rf_we), 32'd0);
    chk("t2_pend3", bus.pend_mask, 32'h0);

    // pipeline hogs the port: queue fills, then starvation
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1;
    for (int t = 1; t <= 9; t++) begin
      bus.pipe_data = 32'(t);
      bus.mdu_valid = 1'b1;
      bus.mdu_rd    = (t == 1) ? 5'd10 : (t == 2) ? 5'd11 : 5'd12;
      bus.mdu_data  = 32'hD000_0000 | 32'(bus.mdu_rd);
      tick();
      if (t == 2) chk("t3_full", 32'(bus.mdu_ready), 32'd0);
      if (t == 8) chk("t3_nostall", 32'(bus.stall_req), 32'd0);
      if (t == 9) chk("t3_stall", 32'(bus.stall_req), 32'd1);
    end
    bus.pipe_valid = 1'b0;
    tick();
    chk("t3_we", 32'(bus.rf_we), 32'd1);
    chk("t3_addr", 32'(bus.rf_waddr), 32'd10);
    chk("t3_data", bus.rf_wdata, 32'hD000_000A);
    chk("t3_unstall", 32'(bus.stall_req), 32'd0);
    tick();
    bus.mdu_valid = 1'b0;
    chk("t3_addr11", 32'(bus.rf_waddr), 32'd11);
    tick();
    chk("t3_addr12", 32'(bus.rf_waddr), 32'd12);
    tick();
    idle_in();

    // x0 result is consumed silently
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd0; bus.fpu_data = 32'hFFFF;
    tick();
    idle_in();
    chk("t4_pend0", bus.pend_mask, 32'd0);
    tick();
    chk("t4_we", 32'(bus.rf_we), 32'd0);
    chk("t4_pend1", bus.pend_mask, 32'd0);

    // async reset with both queues full and a write in the register
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd2; bus.pipe_data = 32'h2222;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'h3;
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd5; bus.fpu_data = 32'h5;
    tick();
    bus.mdu_rd = 5'd4; bus.fpu_rd = 5'd6;
    tick();
    chk("t5_full", 32'(bus.mdu_ready), 32'd0);
    chk("t5_we1", 32'(bus.rf_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_we", 32'(bus.rf_we), 32'd0);
    chk("t5_addr", 32'(bus.rf_waddr), 32'd0);
    chk("t5_data", bus.rf_wdata, 32'd0);
    chk("t5_pend", bus.pend_mask, 32'd0);
    chk("t5_stall", 32'(bus.stall_req), 32'd0);
    chk("t5_mrdy", 32'(bus.mdu_ready), 32'd0);
    idle_in();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_mrdy1", 32'(bus.mdu_ready), 32'd1);
    chk("t5_frdy1", 32'(bus.fpu_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_stale", 32'(bus.rf_we), 32'd0);
    end

    // mixed three-source traffic against the model
    ndut = 0;
    nexp = 0;
    for (int c = 0; c < 400; c++) begin
      bus.pipe_valid = ($urandom_range(0, 9) < 4);
      bus.pipe_rd    = 5'($urandom_range(0, 31));
      bus.pipe_data  = $urandom();
      bus.mdu_valid  = ($urandom_range(0, 9) < 5);
      bus.mdu_rd     = 5'($urandom_range(0, 31));
      bus.mdu_data   = $urandom();
      bus.fpu_valid  = ($urandom_range(0, 9) < 5);
      bus.fpu_rd     = 5'($urandom_range(0, 31));
      bus.fpu_data   = $urandom();
      tick();
    end
    idle_in();
    repeat (30) tick();
    chk("t6_drain", bus.pend_mask, 32'd0);
    chk("t6_writes", 32'(ndut), 32'(nexp));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
